// File: rtl/hazard_unit.sv
// Pipeline interlock controller: per-stage stall/flush decisions, redirect
// deferral across stalls, stall/flush performance counters and MEM-wait watchdog.
module hazard_unit #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1ReadAddr,
  input  logic [4:0]       rs2ReadAddr,
  input  logic             rs1ReadEnable,
  input  logic             rs2ReadEnable,
  input  logic [4:0]       rdWriteAddrE,
  input  logic             rdWriteEnableE,
  input  logic             memReadE,
  input  logic             branchTakenE,
  input  logic             exBusyE,
  input  logic             memStallM,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushD,
  output logic             flushE,
  output logic             flushM,
  output logic             flushW,
  output logic [1:0]       stallReason,
  output logic [CNT_W-1:0] stallCount,
  output logic [CNT_W-1:0] flushCount,
  output logic             hangErr
);

  // state    | meaning
  // RUN      | no multi-cycle wait in progress
  // MEM_WAIT | data memory held the pipe last cycle
  // EX_WAIT  | multi-cycle EX unit held the pipe last cycle
  typedef enum logic [1:0] {RUN, MEM_WAIT, EX_WAIT} state_t;

  localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  state_t             r_state, w_state_nxt;
  logic               r_pend_redir;
  logic [CNT_W-1:0]   r_stall_cnt, r_flush_cnt;
  logic [WAIT_W-1:0]  r_wait_cnt, w_wait_nxt;
  logic               r_hang;
  logic               w_load_use, w_redir;

  assign w_load_use = memReadE & rdWriteEnableE & (rdWriteAddrE != 5'd0) &
                      ((rs1ReadEnable & (rs1ReadAddr == rdWriteAddrE)) |
                       (rs2ReadEnable & (rs2ReadAddr == rdWriteAddrE)));
  assign w_redir    = branchTakenE | r_pend_redir;

  // Gating with rst makes the outputs drop the moment reset asserts.
  always_comb begin
    stallF = 1'b0; stallD = 1'b0; stallE = 1'b0; stallM = 1'b0;
    flushD = 1'b0; flushE = 1'b0; flushM = 1'b0; flushW = 1'b0;
    stallReason = 2'd0;
    if (!rst) begin
      if (memStallM) begin
        {stallF, stallD, stallE, stallM, flushW} = 5'b11111;
        stallReason = 2'd3;
      end else if (exBusyE) begin
        {stallF, stallD, stallE, flushM} = 4'b1111;
        stallReason = 2'd2;
      end else if (w_redir) begin
        {flushD, flushE} = 2'b11;
      end else if (w_load_use) begin
        {stallF, stallD, flushE} = 3'b111;
        stallReason = 2'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:      if (memStallM) w_state_nxt = MEM_WAIT;
                else if (exBusyE) w_state_nxt = EX_WAIT;
      MEM_WAIT: if (!memStallM) w_state_nxt = exBusyE ? EX_WAIT : RUN;
      EX_WAIT:  if (memStallM) w_state_nxt = MEM_WAIT;
                else if (!exBusyE) w_state_nxt = RUN;
      default:  w_state_nxt = RUN;
    endcase
  end

  // Saturate at TIMEOUT so a very long wait cannot wrap the watchdog.
  always_comb begin
    w_wait_nxt = r_wait_cnt;
    if (!memStallM)
      w_wait_nxt = '0;
    else if ((r_state == MEM_WAIT) && (r_wait_cnt != WAIT_W'(TIMEOUT)))
      w_wait_nxt = r_wait_cnt + WAIT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= RUN;
      r_pend_redir <= 1'b0;
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
      r_wait_cnt   <= '0;
      r_hang       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      if (memStallM && (w_wait_nxt == WAIT_W'(TIMEOUT)))
        r_hang <= 1'b1;
      if (stallF)
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (flushD) begin
        r_flush_cnt  <= r_flush_cnt + CNT_W'(1);
        r_pend_redir <= 1'b0;
      end else if (branchTakenE && (memStallM || exBusyE)) begin
        r_pend_redir <= 1'b1;
      end
    end
  end

  assign stallCount = r_stall_cnt;
  assign flushCount = r_flush_cnt;
  assign hangErr    = r_hang;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios followed by random
// traffic, all compared against a rule-level reference model.
module tb_hazard_unit;
  localparam int CNT_W   = 6;
  localparam int TIMEOUT = 4;
  localparam int MOD     = 64;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs1ReadAddr, rs2ReadAddr, rdWriteAddrE;
  logic rs1ReadEnable, rs2ReadEnable, rdWriteEnableE, memReadE;
  logic branchTakenE, exBusyE, memStallM;
  logic stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW;
  logic [1:0] stallReason;
  logic [CNT_W-1:0] stallCount, flushCount;
  logic hangErr;

  hazard_unit #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .rs1ReadAddr(rs1ReadAddr), .rs2ReadAddr(rs2ReadAddr),
    .rs1ReadEnable(rs1ReadEnable), .rs2ReadEnable(rs2ReadEnable),
    .rdWriteAddrE(rdWriteAddrE), .rdWriteEnableE(rdWriteEnableE),
    .memReadE(memReadE), .branchTakenE(branchTakenE),
    .exBusyE(exBusyE), .memStallM(memStallM),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
    .stallReason(stallReason), .stallCount(stallCount),
    .flushCount(flushCount), .hangErr(hangErr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model: counters as integers, watchdog as a run length of MEM stalls
  int m_sc, m_fc, m_run;
  bit m_pend, m_hang;
  logic [7:0] e_ctl;   // {stallF,stallD,stallE,stallM,flushD,flushE,flushM,flushW}
  logic [1:0] e_rsn;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_comb();
    bit hit1, hit2, lu;
    hit1 = rs1ReadEnable && (rs1ReadAddr == rdWriteAddrE);
    hit2 = rs2ReadEnable && (rs2ReadAddr == rdWriteAddrE);
    lu   = memReadE && rdWriteEnableE && (rdWriteAddrE != 0) && (hit1 || hit2);
    e_ctl = 8'h00;
    e_rsn = 2'd0;
    if (rst)                        ;
    else if (memStallM)             begin e_ctl = 8'b1111_0001; e_rsn = 2'd3; end
    else if (exBusyE)               begin e_ctl = 8'b1110_0010; e_rsn = 2'd2; end
    else if (branchTakenE || m_pend) e_ctl = 8'b0000_1100;
    else if (lu)                    begin e_ctl = 8'b1100_0100; e_rsn = 2'd1; end
  endtask

  task automatic model_reset();
    m_sc = 0; m_fc = 0; m_run = 0; m_pend = 0; m_hang = 0;
  endtask

  task automatic model_edge();
    if (e_ctl[7]) m_sc = (m_sc + 1) % MOD;
    if (e_ctl[3]) m_fc = (m_fc + 1) % MOD;
    if (e_ctl[3]) m_pend = 0;
    else if (branchTakenE && (memStallM || exBusyE)) m_pend = 1;
    if (memStallM) begin
      m_run++;
      if (m_run > TIMEOUT) m_hang = 1;
    end else begin
      m_run = 0;
    end
  endtask

  task automatic settle();
    #1;
    model_comb();
    chk("ctl", {stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW}, e_ctl);
    chk("reason", stallReason, e_rsn);
    chk("stallCount", stallCount, m_sc);
    chk("flushCount", flushCount, m_fc);
    chk("hangErr", hangErr, m_hang);
  endtask

  task automatic adv();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_in(input logic [4:0] r1, input logic e1, input logic [4:0] r2,
                        input logic e2, input logic [4:0] rd, input logic we,
                        input logic mr, input logic br, input logic ex, input logic ms);
    rs1ReadAddr = r1; rs1ReadEnable = e1; rs2ReadAddr = r2; rs2ReadEnable = e2;
    rdWriteAddrE = rd; rdWriteEnableE = we; memReadE = mr;
    branchTakenE = br; exBusyE = ex; memStallM = ms;
  endtask

  // assumes time is just after a rising edge
  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    settle();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #2;
    settle();
    chk("rst_ctl", {stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW}, 8'h00);
    @(posedge clk); #1;
    rst = 1'b0;

    // load-use on rs1, then cleared hazard
    set_in(5, 1, 0, 0, 5, 1, 1, 0, 0, 0);
    settle();
    chk("lu_stall", {stallF, stallD, flushE, stallReason}, 5'b111_01);
    adv();
    set_in(5, 1, 0, 0, 0, 1, 1, 0, 0, 0);
    settle();
    chk("lu_after", {stallF, stallD, flushE}, 3'b000);
    chk("lu_count", stallCount, 1);
    adv();

    // zero register and disabled read port never stall
    set_in(0, 1, 0, 0, 0, 1, 1, 0, 0, 0);
    settle(); chk("x0_nostall", stallF, 1'b0); adv();
    set_in(5, 0, 0, 0, 5, 1, 1, 0, 0, 0);
    settle(); chk("en0_nostall", stallF, 1'b0); adv();
    set_in(0, 0, 7, 1, 7, 1, 1, 0, 0, 0);
    settle(); chk("lu_rs2", stallF, 1'b1); adv();

    // branch wins over load-use
    do_reset();
    set_in(5, 1, 0, 0, 5, 1, 1, 1, 0, 0);
    settle();
    chk("br_lu", {flushD, flushE, stallF}, 3'b110);
    adv();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("br_fc", flushCount, 1);
    adv();

    // redirect during MEM wait is deferred until the stall ends
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, (i == 0), 0, 1);
      settle();
      chk("mw_hold", {stallM, flushW, flushD}, 3'b110);
      adv();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("mw_redir", {flushD, flushE}, 2'b11);
    adv();
    settle();
    chk("mw_once", flushD, 1'b0);
    chk("mw_fc", flushCount, 1);
    chk("mw_sc", stallCount, 3);
    adv();

    // second pulse while pending is absorbed
    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 0); settle(); adv();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 0); settle(); adv();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); settle(); adv();
    settle();
    chk("absorb_fc", flushCount, 1);
    adv();

    // nested waits: MEM then EX
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 0, (i >= 2), (i < 2));
      settle();
      chk("nest_rsn", stallReason, (i < 2) ? 2'd3 : 2'd2);
      chk("nest_flushM", flushM, (i >= 2));
      adv();
    end

    // watchdog: six MEM-wait cycles, error appears in the sixth and sticks
    do_reset();
    for (int i = 1; i <= 6; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      settle();
      chk("wd_hang", hangErr, (i == 6));
      adv();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("wd_sticky", hangErr, 1'b1);
    adv();

    // reset during a stall with a pending redirect
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 1); settle(); adv();
    rst = 1'b1;
    #1;
    chk("rst_mid_ctl", {stallF, stallD, stallE, stallM, flushD, flushE, flushM, flushW}, 8'h00);
    chk("rst_mid_cnt", {stallCount, flushCount, hangErr}, '0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("rst_pend_lost", flushD, 1'b0);
    adv();

    // stall counter wrap
    do_reset();
    for (int i = 0; i < 70; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      settle();
      adv();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("wrap_sc", stallCount, 6);
    adv();

    // random traffic
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        set_in(5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
               5'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 9) < 5), 1'($urandom_range(0, 9) < 2),
               1'($urandom_range(0, 9) < 2), 1'($urandom_range(0, 19) < 3));
        settle();
        adv();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline interlock controller for the 5-stage core (F/D/E/M/W).
- Sits directly upstream of the forwarding control block. It decides stall, bubble and flush per stage, so the EX/MEM destination addresses seen by forwarding are either real instructions or bubbles (rd=0).
- Resolves the following, which forwarding cannot cover:
  - load-use hazards
  - multi-cycle EX busy
  - data-memory wait
  - branch redirect, including redirects that arrive during a stall
- Also keeps stall/flush counters and a memory-wait watchdog.

Parameters:
- CNT_W, 32, width of the stallCount and flushCount performance counters (wrap on overflow).
- TIMEOUT, 255, maximum consecutive MEM_WAIT cycles before hangErr is raised.

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- rs1ReadAddr  input  5  rs1 of instruction in D.
- rs2ReadAddr  input  5  rs2 of instruction in D.
- rs1ReadEnable  input  1  D instruction reads rs1.
- rs2ReadEnable  input  1  D instruction reads rs2.
- rdWriteAddrE  input  5  rd of instruction in E.
- rdWriteEnableE  input  1  E instruction writes rd.
- memReadE  input  1  E instruction is a load.
- branchTakenE  input  1  one-cycle pulse: EX resolved a taken branch/jump.
- exBusyE  input  1  multi-cycle unit in E not finished.
- memStallM  input  1  MEM stage waiting on data memory.
- stallF  output  1  hold PC.
- stallD  output  1  hold F/D register.
- stallE  output  1  hold D/E register.
- stallM  output  1  hold E/M register.
- flushD  output  1  load bubble into F/D register.
- flushE  output  1  load bubble into D/E register.
- flushM  output  1  load bubble into E/M register.
- flushW  output  1  load bubble into M/W register.
- stallReason  output  2  0 none, 1 load-use, 2 EX busy, 3 MEM wait.
- stallCount  output  CNT_W  cycles with stallF=1.
- flushCount  output  CNT_W  redirect flushes applied.
- hangErr  output  1  sticky watchdog error.

Behaviour:
- Reset (async, rst=1):
  - state=RUN, pendRedir=0.
  - All stall/flush outputs 0, stallReason=0.
  - Both counters 0, waitCnt=0, hangErr=0.
- loadUse = memReadE & rdWriteEnableE & (rdWriteAddrE≠0) & ((rs1ReadEnable & rs1ReadAddr==rdWriteAddrE) | (rs2ReadEnable & rs2ReadAddr==rdWriteAddrE)).
- redir = branchTakenE | pendRedir.
- Stage controls are combinational from current inputs, state and pendRedir, with strict priority (same-cycle, zero latency):
  1. memStallM: stallF=stallD=stallE=stallM=1, flushW=1, stallReason=3.
  2. exBusyE: stallF=stallD=stallE=1, flushM=1, stallReason=2.
  3. redir: flushD=flushE=1. No stall; load-use is suppressed because D holds a wrong-path instruction. stallReason=0.
  4. loadUse: stallF=stallD=1, flushE=1, stallReason=1.
  5. Otherwise: all outputs 0.
- Outputs driven at a given priority level are listed above; every other stall/flush output is 0 in that case.
- FSM (registered):
  - RUN -> MEM_WAIT when memStallM.
  - RUN -> EX_WAIT when exBusyE & !memStallM.
  - MEM_WAIT -> RUN when !memStallM & !exBusyE.
  - MEM_WAIT -> EX_WAIT when !memStallM & exBusyE.
  - EX_WAIT -> MEM_WAIT when memStallM.
  - EX_WAIT -> RUN when !exBusyE & !memStallM.
- Pending redirect:
  - If branchTakenE=1 while memStallM or exBusyE is 1, set pendRedir at the edge.
  - The flush is applied in the first cycle with neither stall active (priority 3); pendRedir clears at the end of that cycle.
  - A second pulse while pending is absorbed: only one flush occurs.
- Counters:
  - stallCount += 1 each cycle stallF=1.
  - flushCount += 1 each cycle a redirect flush is applied (flushD=1).
  - Both counters wrap modulo 2^CNT_W.
- Watchdog:
  - waitCnt increments each cycle in MEM_WAIT with memStallM=1, and clears on any cycle with memStallM=0.
  - When waitCnt reaches TIMEOUT, hangErr=1 from the next cycle.
  - hangErr is cleared only by rst.
- rdWriteAddrE=0 never creates a load-use stall.
- Reset mid-stall: outputs drop to 0 immediately (asynchronous) and pendRedir is lost.

Test Plan:
- Load-use: memReadE=1, rdWriteEnableE=1, rdWriteAddrE=5, rs1ReadAddr=5, rs1ReadEnable=1 for 1 cycle -> stallF=stallD=flushE=1, stallReason=1, stallCount=1; next cycle with rdWriteAddrE=0 -> all 0.
- Zero register: same stimulus with rdWriteAddrE=0 and rs1ReadAddr=0 -> no stall. Same stimulus with rs1ReadEnable=0 -> no stall.
- Branch beats load-use: branchTakenE=1 together with the load-use condition -> flushD=flushE=1, stallF=0, flushCount=1.
- Redirect during MEM wait: memStallM=1 for 3 cycles, branchTakenE pulsed in cycle 1 -> stallM=flushW=1 for 3 cycles; in cycle 4 flushD=flushE=1 once; flushCount=1, stallCount=3.
- Nested waits: memStallM for 2 cycles, then exBusyE for 2 cycles -> state RUN→MEM_WAIT→EX_WAIT→RUN; stallReason 3,3,2,2; flushM=1 only in the EX_WAIT cycles.
- Watchdog and reset: TIMEOUT=4, memStallM held for 6 cycles -> hangErr=1 after the 4th wait count and stays 1 after memStallM drops. Asserting rst mid-stall -> all outputs 0 immediately, counters 0.
